// File: rtl/toy_cpu_pkg.sv
// rtl/toy_cpu_pkg.sv - shared widths, word/address types and loader FSM states for the toy CPU memory
package toy_cpu_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int CNT_W  = $clog2(DATA_W);

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2,
        ST_DUMP = 2'd3
    } state_e;

endpackage

// File: rtl/toy_mem_loader.sv
// rtl/toy_mem_loader.sv - serial word loader FSM driving the memory write port
// Optional serial readback of the whole store is built when TOY_MEM_DUMP_EN is defined.
module toy_mem_loader
    import toy_cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en_i,
    input  logic              load_bit_i,
`ifdef TOY_MEM_DUMP_EN
    input  logic [DATA_W-1:0] dump_word_i,
`endif
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] ptr_o,
    output logic [DATA_W-1:0] wr_data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              dump_out_o
);

    localparam cnt_t  CNT_MAX = cnt_t'(DATA_W - 1);
    localparam addr_t PTR_MAX = addr_t'(DEPTH - 1);

    state_e            state_q, state_d;
    cnt_t              cnt_q, cnt_d;
    addr_t             ptr_q, ptr_d;
    // The completed word is formed combinationally, so only DATA_W-1 bits are stored.
    logic [DATA_W-2:0] shift_q, shift_d;
    logic              done_q, done_d;
    logic              dump_q, dump_d;
    word_t             word_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            shift_q <= '0;
            done_q  <= 1'b0;
            dump_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            shift_q <= shift_d;
            done_q  <= done_d;
            dump_q  <= dump_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        shift_d = shift_q;
        done_d  = done_q;
        dump_d  = 1'b0;
        wr_en_o = 1'b0;
        word_c  = {shift_q, load_bit_i};
        case (state_q)
            ST_IDLE: begin
                if (load_en_i) begin
                    state_d = ST_LOAD;
                    ptr_d   = '0;
                    cnt_d   = '0;
                end
            end
            ST_LOAD: begin
                if (!load_en_i) begin
                    state_d = ST_IDLE;
                end else begin
                    shift_d = word_c[DATA_W-2:0];
                    if (cnt_q == CNT_MAX) begin
                        wr_en_o = 1'b1;
                        cnt_d   = '0;
                        ptr_d   = ptr_q + 1'b1;
                        if (ptr_q == PTR_MAX) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (load_en_i) begin
                    ptr_d   = '0;
                    cnt_d   = '0;
`ifdef TOY_MEM_DUMP_EN
                    state_d = load_bit_i ? ST_DUMP : ST_LOAD;
`else
                    state_d = ST_LOAD;
`endif
                end
            end
`ifdef TOY_MEM_DUMP_EN
            ST_DUMP: begin
                if (!load_en_i) begin
                    state_d = ST_DONE;
                end else begin
                    dump_d = dump_word_i[CNT_MAX - cnt_q];
                    if (cnt_q == CNT_MAX) begin
                        cnt_d = '0;
                        ptr_d = ptr_q + 1'b1;
                        if (ptr_q == PTR_MAX) begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    assign ptr_o      = ptr_q;
    assign wr_data_o  = word_c;
    assign busy_o     = (state_q == ST_LOAD) || (state_q == ST_DUMP);
    assign done_o     = done_q;
    assign dump_out_o = dump_q;

endmodule

// File: rtl/toy_mem_responder.sv
// rtl/toy_mem_responder.sv - 16x8 store answering toy CPU bus cycles, preloadable over a serial port
// Optional serial readback (dump_out) is built when TOY_MEM_DUMP_EN is defined.
module toy_mem_responder
    import toy_cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              we,
    output logic [DATA_W-1:0] rdata,
    input  logic              load_en,
    input  logic              load_bit,
    output logic              load_busy,
    output logic              load_done,
    output logic              dump_out
);

    word_t mem_q [DEPTH];
    logic  ld_wr_en;
    addr_t ld_ptr;
    word_t ld_wr_data;

    toy_mem_loader u_loader (
        .clk        (clk),
        .rst        (rst),
        .load_en_i  (load_en),
        .load_bit_i (load_bit),
`ifdef TOY_MEM_DUMP_EN
        .dump_word_i(mem_q[ld_ptr]),
`endif
        .wr_en_o    (ld_wr_en),
        .ptr_o      (ld_ptr),
        .wr_data_o  (ld_wr_data),
        .busy_o     (load_busy),
        .done_o     (load_done),
        .dump_out_o (dump_out)
    );

    // The loader owns the write port whenever it is busy; CPU writes are dropped then.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (ld_wr_en) begin
            mem_q[ld_ptr] <= ld_wr_data;
        end else if (we && !load_busy) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: tb/tb_toy_mem_responder.sv
// tb/tb_toy_mem_responder.sv - directed/randomized self-checking bench for toy_mem_responder
module tb_toy_mem_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic       we;
    logic [7:0] rdata;
    logic       load_en;
    logic       load_bit;
    logic       load_busy;
    logic       load_done;
    logic       dump_out;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] model [16];
    logic [7:0] lw    [16];
    logic       mdone;

    always #5 clk = ~clk;

    toy_mem_responder dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .wdata    (wdata),
        .we       (we),
        .rdata    (rdata),
        .load_en  (load_en),
        .load_bit (load_bit),
        .load_busy(load_busy),
        .load_done(load_done),
        .dump_out (dump_out)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < 16; i++) begin
            addr = 4'(i);
            #1;
            chk($sformatf("%s_mem%0d", tag, i), rdata, model[i]);
        end
    endtask

    task automatic cpu_write(input logic [3:0] a, input logic [7:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        step();
        we    = 1'b0;
        model[a] = d;
    endtask

    // Enter LOAD, then shift nbits of lw[] MSB first; optionally attempt a CPU write mid-load.
    task automatic run_load(input string tag, input int nbits, input bit poke);
        logic exp_done;
        load_en  = 1'b1;
        load_bit = 1'b0;
        step();
        chk({tag, "_busy_entry"}, load_busy, 1);
        for (int b = 0; b < nbits; b++) begin
            load_bit = lw[b / 8][7 - (b % 8)];
            if (poke && b == 20) begin
                addr  = 4'h0;
                wdata = 8'hFF;
                we    = 1'b1;
            end
            step();
            we = 1'b0;
            exp_done = mdone | (b == 127);
            chk($sformatf("%s_busy_b%0d", tag, b), load_busy, (b == 127) ? 0 : 1);
            chk($sformatf("%s_done_b%0d", tag, b), load_done, exp_done);
        end
        for (int i = 0; i < nbits / 8; i++) model[i] = lw[i];
        if (nbits >= 128) mdone = 1'b1;
    endtask

    initial begin
        logic [3:0] ra;
        logic [7:0] rd;
        rst = 1'b1; addr = '0; wdata = '0; we = 1'b0; load_en = 1'b0; load_bit = 1'b0;
        mdone = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = 8'h00;

        // Reset
        step();
        step();
        rst = 1'b0;
        sweep("rst");
        chk("rst_busy", load_busy, 0);
        chk("rst_done", load_done, 0);
        chk("rst_dump", dump_out, 0);

        // CPU write/read
        cpu_write(4'h3, 8'hA5);
        addr = 4'h3; #1;
        chk("wr_a3", rdata, 8'hA5);
        addr = 4'h4; #1;
        chk("wr_a4", rdata, 8'h00);
        for (int k = 0; k < 4; k++) begin
            ra = 4'($urandom_range(0, 15));
            rd = 8'($urandom_range(0, 255));
            cpu_write(ra, rd);
        end
        sweep("rndwr");

        // Full load of 0x10+i with a CPU write attempt while busy
        for (int i = 0; i < 16; i++) lw[i] = 8'(8'h10 + i);
        run_load("full", 128, 1'b1);
        load_en = 1'b0;
        step();
        chk("full_busy_after", load_busy, 0);
        chk("full_done_after", load_done, 1);
        sweep("full");

        // Start from DONE with load_bit=1: dump with the feature, plain reload of identical data without
        load_en  = 1'b1;
        load_bit = 1'b1;
        step();
        chk("dump_busy_entry", load_busy, 1);
        for (int k = 0; k < 128; k++) begin
            load_bit = model[k / 8][7 - (k % 8)];
            step();
`ifdef TOY_MEM_DUMP_EN
            chk($sformatf("dump_bit%0d", k), dump_out, model[k / 8][7 - (k % 8)]);
`else
            chk($sformatf("dump_zero%0d", k), dump_out, 0);
`endif
            chk($sformatf("dump_busy%0d", k), load_busy, (k == 127) ? 0 : 1);
        end
        load_en = 1'b0;
        step();
        chk("dump_done", load_done, 1);
        chk("dump_idle_out", dump_out, 0);
        sweep("postdump");

        // Reload random words starting from DONE
        for (int i = 0; i < 16; i++) lw[i] = 8'($urandom_range(0, 255));
        run_load("reload", 128, 1'b0);
        load_en = 1'b0;
        step();
        sweep("reload");

        // Abort after 2.5 words
        rst = 1'b1;
        step();
        rst = 1'b0;
        mdone = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        for (int i = 0; i < 16; i++) lw[i] = 8'($urandom_range(1, 255));
        run_load("abort", 20, 1'b0);
        load_en = 1'b0;
        step();
        chk("abort_busy", load_busy, 0);
        chk("abort_done", load_done, 0);
        sweep("abort");
        rd = 8'($urandom_range(0, 255));
        cpu_write(4'h9, rd);
        sweep("abort_cpuwr");

        // Reset at bit 5 of a load clears everything
        load_en = 1'b1;
        step();
        for (int b = 0; b < 5; b++) begin
            load_bit = 1'b1;
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        load_en = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        chk("rstmid_busy", load_busy, 0);
        chk("rstmid_done", load_done, 0);
        sweep("rstmid");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/toy_mem_responder.md
Name: toy_mem_responder

Overview:
Memory-side responder for the 4-bit toy CPU bus (addr[3:0], write data, read data, we). It holds the 16x8 program/data store the CPU fetches from and writes to. A serial load port preloads the store before the CPU is released from reset. It sits beside the cpu instance in the top-level wrapper and answers every CPU bus cycle.

Parameters:
ADDR_W, 4, address width; depth = 2**ADDR_W words
DATA_W, 8, word width in bits

Ports:
clk  input  1  single clock for bus and load port
rst  input  1  synchronous, active-high reset
addr  input  ADDR_W  CPU word address
wdata  input  DATA_W  CPU write data (CPU data_out)
we  input  1  CPU write strobe, sampled at clk rising edge
rdata  output  DATA_W  read data to CPU (CPU data_in)
load_en  input  1  serial load session active
load_bit  input  1  serial load data, MSB of each word first
load_busy  output  1  high while in LOAD state
load_done  output  1  sticky; set once all words are loaded
dump_out  output  1  serial readback bit (see Optional Feature)

Behaviour:
- Reset (synchronous, rst=1 at clk edge):
  - all memory words := 0
  - FSM := IDLE; bit counter := 0; load pointer := 0; shift register := 0
  - load_busy=0, load_done=0, dump_out=0
  - rdata therefore reads 0. Reset mid-load aborts the load fully.
- Read path: rdata = mem[addr], combinational, zero cycles of latency. A write becomes visible on rdata the cycle after the write edge.
- CPU write: in IDLE or DONE, when we=1 at an edge, mem[addr] := wdata.
- FSM states:
  - IDLE: load_en=1 -> LOAD, with pointer := 0 and bit counter := 0.
  - LOAD: each edge with load_en=1:
    - shift := {shift[DATA_W-2:0], load_bit}; counter increments.
    - When counter == DATA_W-1, the completed word {shift[DATA_W-2:0], load_bit} is written to mem[pointer] on that same edge. Counter := 0; pointer increments.
    - If pointer == 2**ADDR_W-1 at that write, go to DONE and set load_done.
  - LOAD with load_en=0: return to IDLE. The partial word is discarded and already-written words are kept. load_done stays unchanged.
  - DONE: load_en=1 -> LOAD, restarting at pointer 0. load_done stays set until rst.
- load_busy = (state == LOAD).
- Priority: in LOAD, we is ignored and the loader owns the write port. A CPU write and a loader write never happen on the same edge.
- Pointer wraps naturally at ADDR_W bits. DONE is reached only via the final-word write.

Optional Feature:
Macro TOY_MEM_DUMP_EN.
- With the macro:
  - A rising edge of load_en while in DONE starts a dump instead of a reload, when load_bit=1 on that first edge. Otherwise a normal reload starts.
  - Dump shifts out mem[0..15], MSB first, one bit per clock on dump_out, beginning the edge after entry to DUMP.
  - load_busy=1 during DUMP. Dump returns to DONE after 16*DATA_W bits, or immediately if load_en drops.
- Without the macro: no DUMP state; dump_out tied to 0.

Decomposition:
- Shared package toy_cpu_pkg holds:
  - ADDR_W and DATA_W constants
  - the word_t and addr_t typedefs
  - the FSM state enum (IDLE, LOAD, DONE, DUMP)
- One natural sub-module, toy_mem_loader: the serial shift register, bit counter, pointer and FSM. It outputs a write request (addr, data, strobe) to the array in toy_mem_responder.

Test Plan:
1. Reset: rst=1 for 2 cycles, then sweep addr 0..15 -> rdata=0x00 at every address; load_busy=0, load_done=0.
2. CPU write/read: we=1, addr=0x3, wdata=0xA5 for one edge -> next cycle rdata=0xA5 at addr 3, rdata=0x00 at addr 4.
3. Full load: load_en=1, shift 128 bits encoding words 0x10+i -> load_done rises on edge 128; mem[i]=0x10+i for all i; load_busy=1 throughout, then 0.
4. Abort: load 2.5 words (20 bits), then load_en=0 -> mem[0], mem[1] written, mem[2] unchanged, state IDLE, load_done=0. Also reassert rst at bit 5 of a load -> memory all 0.
5. Write during load: we=1, addr=0x0, wdata=0xFF while load_busy=1 -> ignored; mem[0] holds the loaded value.
6. TOY_MEM_DUMP_EN: after test 3, load_en=1 with load_bit=1 -> dump_out emits 0x10,0x11,…,0x1F MSB first over 128 cycles; without the macro dump_out stays 0.
